// File: rtl/ppm_frame_buffer.sv
`timescale 1ns/1ps
// ppm_frame_buffer: captures a decoded PPM byte stream into a local buffer,
// runs a CRC-16 (ISO/IEC 13239, reflected 0x8408, init 0xFFFF) over the
// accepted bytes, closes the frame on an inter-byte timeout and then holds it
// until the host acknowledges it.
module ppm_frame_buffer #(
    parameter  int DEPTH   = 32,
    parameter  int TIMEOUT = 4096,
    localparam int LW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    Dout,
    input  logic          D_en,
    input  logic          F_en,
    output logic          frame_valid,
    output logic          frame_done,
    output logic [LW-1:0] frame_len,
    output logic          crc_ok,
    output logic          overflow,
    output logic          frame_lost,
    input  logic          frame_ack,
    input  logic          rd_en,
    input  logic [7:0]    rd_addr,
    output logic [7:0]    rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [8:0]    DEPTH_A   = 9'(DEPTH);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
    localparam logic [15:0]   CRC_INIT  = 16'hFFFF;
    localparam logic [15:0]   CRC_GOOD  = 16'hF0B8;
    localparam logic [15:0]   CRC_POLY  = 16'h8408;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q,    state_d;
    logic [LW-1:0] len_q,      len_d;
    logic [15:0]   crc_q,      crc_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic          overflow_q, overflow_d;
    logic          crc_ok_q,   crc_ok_d;
    logic          valid_q,    valid_d;
    logic          done_q,     done_d;
    logic          lost_q,     lost_d;
    logic [7:0]    rd_data_q;
    logic          wr_en;

    logic [7:0]    mem [DEPTH];

    // Byte-wide CRC: eight chained single-bit steps, data taken LSB first.
    logic [15:0] crc_chain [9];
    assign crc_chain[0] = crc_q;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
            logic [15:0] shifted;
            assign shifted = {1'b0, crc_chain[gi][15:1]};
            assign crc_chain[gi+1] = (crc_chain[gi][0] ^ Dout[gi]) ? (shifted ^ CRC_POLY)
                                                                   : shifted;
        end
    endgenerate

    // Next-state and output decode for the capture FSM.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        crc_d      = crc_q;
        timer_d    = timer_q;
        overflow_d = overflow_q;
        crc_ok_d   = crc_ok_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        lost_d     = lost_q;
        wr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                // A coincident D_en byte is dropped: the frame starts empty.
                if (F_en) begin
                    state_d    = RECV;
                    len_d      = '0;
                    crc_d      = CRC_INIT;
                    overflow_d = 1'b0;
                    timer_d    = '0;
                end
            end
            RECV: begin
                if (F_en) begin
                    len_d      = '0;
                    crc_d      = CRC_INIT;
                    overflow_d = 1'b0;
                    timer_d    = '0;
                end else if (D_en) begin
                    if (len_q < DEPTH_L) begin
                        wr_en = 1'b1;
                        len_d = len_q + LW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    // Overflow bytes still feed the CRC so the residue reflects
                    // everything that actually arrived.
                    crc_d   = crc_chain[8];
                    timer_d = '0;
                end else if (timer_q == TIMER_MAX) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    done_d   = 1'b1;
                    crc_ok_d = (crc_q == CRC_GOOD) && (len_q >= LW'(3)) && !overflow_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: begin
                if (frame_ack) begin
                    valid_d    = 1'b0;
                    crc_ok_d   = 1'b0;
                    overflow_d = 1'b0;
                    lost_d     = 1'b0;
                    if (F_en) begin
                        state_d = RECV;
                        len_d   = '0;
                        crc_d   = CRC_INIT;
                        timer_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (F_en) begin
                    lost_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            crc_q      <= CRC_INIT;
            timer_q    <= '0;
            overflow_q <= 1'b0;
            crc_ok_q   <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
            crc_ok_q   <= crc_ok_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            lost_q     <= lost_d;
        end
    end

    // Frame storage write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len_q[AW-1:0]] <= Dout;
        end
    end

    // Registered read port; out-of-range addresses read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else if (rd_en) begin
            rd_data_q <= ({1'b0, rd_addr} < DEPTH_A) ? mem[rd_addr[AW-1:0]] : 8'h00;
        end
    end

    assign frame_valid = valid_q;
    assign frame_done  = done_q;
    assign frame_len   = len_q;
    assign crc_ok      = crc_ok_q;
    assign overflow    = overflow_q;
    assign frame_lost  = lost_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_ppm_frame_buffer.sv
`timescale 1ns/1ps
// Bench for ppm_frame_buffer: two instances (DEPTH=32 and DEPTH=4, both with
// TIMEOUT=16). Expected frames and read data are queued when stimulus is
// issued and checked by an independent monitor.
module tb_ppm_frame_buffer;

    localparam int TO = 16;

    typedef struct {
        int   u;
        int   len;
        logic ok;
        logic ovf;
    } frm_t;

    typedef struct {
        int         u;
        logic [7:0] d;
    } rd_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dout    [2];
    logic       d_en    [2];
    logic       f_en    [2];
    logic       ack     [2];
    logic       rd_en   [2];
    logic [7:0] rd_addr [2];
    logic       fv      [2];
    logic       fd      [2];
    logic       ok      [2];
    logic       ovf     [2];
    logic       lost    [2];
    logic [7:0] rdd     [2];
    logic [5:0] len0;
    logic [2:0] len1;
    logic [8:0] flen    [2];
    bit         rd_pend [2];

    frm_t fq[$];
    rd_t  rq[$];

    int checks   = 0;
    int failures = 0;

    logic [7:0] good_frame [$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                                   8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    logic [7:0] bad_frame  [$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                                   8'h37, 8'h38, 8'h39, 8'h6E, 8'h91};
    logic [7:0] ovf_frame  [$] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    logic [7:0] short_ok   [$] = '{8'h00, 8'h78, 8'hF0};

    assign flen[0] = {3'b000, len0};
    assign flen[1] = {6'b000000, len1};

    always #5 clk = ~clk;

    ppm_frame_buffer #(.DEPTH(32), .TIMEOUT(TO)) u_big (
        .clk(clk), .rst_n(rst_n), .Dout(dout[0]), .D_en(d_en[0]), .F_en(f_en[0]),
        .frame_valid(fv[0]), .frame_done(fd[0]), .frame_len(len0), .crc_ok(ok[0]),
        .overflow(ovf[0]), .frame_lost(lost[0]), .frame_ack(ack[0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rdd[0])
    );

    ppm_frame_buffer #(.DEPTH(4), .TIMEOUT(TO)) u_small (
        .clk(clk), .rst_n(rst_n), .Dout(dout[1]), .D_en(d_en[1]), .F_en(f_en[1]),
        .frame_valid(fv[1]), .frame_done(fd[1]), .frame_len(len1), .crc_ok(ok[1]),
        .overflow(ovf[1]), .frame_lost(lost[1]), .frame_ack(ack[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rdd[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a result.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rd_pend[u]) begin
                if (rq.size() == 0) begin
                    check($sformatf("u%0d unexpected_read", u), 1, 0);
                end else begin
                    rd_t r;
                    r = rq.pop_front();
                    check($sformatf("u%0d read_unit", u), u, r.u);
                    check($sformatf("u%0d rd_data", u), {24'd0, rdd[u]}, {24'd0, r.d});
                end
            end
            rd_pend[u] = rd_en[u];
            if (fd[u] === 1'b1) begin
                if (fq.size() == 0) begin
                    check($sformatf("u%0d unexpected_frame_done", u), 1, 0);
                end else begin
                    frm_t f;
                    f = fq.pop_front();
                    check($sformatf("u%0d frame_unit", u), u, f.u);
                    check($sformatf("u%0d frame_len", u), {23'd0, flen[u]}, f.len);
                    check($sformatf("u%0d crc_ok", u), {31'd0, ok[u]}, {31'd0, f.ok});
                    check($sformatf("u%0d overflow", u), {31'd0, ovf[u]}, {31'd0, f.ovf});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_fen(input int u);
        f_en[u] = 1'b1;
        step();
        f_en[u] = 1'b0;
    endtask

    task automatic pulse_ack(input int u);
        ack[u] = 1'b1;
        step();
        ack[u] = 1'b0;
    endtask

    task automatic send_byte(input int u, input logic [7:0] b);
        dout[u] = b;
        d_en[u] = 1'b1;
        step();
        d_en[u] = 1'b0;
    endtask

    task automatic send_bytes(input int u, input logic [7:0] data [$], input int g);
        for (int i = 0; i < data.size(); i++) begin
            if (i > 0) gap(g);
            send_byte(u, data[i]);
        end
    endtask

    task automatic expect_frame(input int u, input int len, input logic fok, input logic fovf);
        frm_t f;
        f.u = u; f.len = len; f.ok = fok; f.ovf = fovf;
        fq.push_back(f);
    endtask

    task automatic rd(input int u, input logic [7:0] addr, input logic [7:0] exp);
        rd_t r;
        r.u = u; r.d = exp;
        rq.push_back(r);
        rd_addr[u] = addr;
        rd_en[u]   = 1'b1;
        step();
        rd_en[u]   = 1'b0;
    endtask

    task automatic check_zero(input int u, input string tag);
        check($sformatf("u%0d %s flags", u, tag),
              {27'd0, fv[u], fd[u], ok[u], ovf[u], lost[u]}, 0);
        check($sformatf("u%0d %s frame_len", u, tag), {23'd0, flen[u]}, 0);
        check($sformatf("u%0d %s rd_data", u, tag), {24'd0, rdd[u]}, 0);
    endtask

    // Last byte just went in: frame must close exactly TIMEOUT edges later.
    task automatic check_close_timing(input int u);
        gap(TO - 1);
        check($sformatf("u%0d valid_before_timeout", u), {31'd0, fv[u]}, 0);
        step();
        check($sformatf("u%0d valid_at_timeout", u), {31'd0, fv[u]}, 1);
        check($sformatf("u%0d done_at_timeout", u), {31'd0, fd[u]}, 1);
        step();
        check($sformatf("u%0d done_one_cycle", u), {31'd0, fd[u]}, 0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            dout[u] = 8'h00; d_en[u] = 1'b0; f_en[u] = 1'b0; ack[u] = 1'b0;
            rd_en[u] = 1'b0; rd_addr[u] = 8'h00; rd_pend[u] = 1'b0;
        end
        gap(3);
        check_zero(0, "reset");
        check_zero(1, "reset");
        rst_n = 1'b1;
        gap(2);

        // Valid frame "123456789" + CRC bytes, one byte every 4 clocks.
        expect_frame(0, 11, 1'b1, 1'b0);
        pulse_fen(0);
        send_bytes(0, good_frame, 3);
        check_close_timing(0);
        rd(0, 8'd40, 8'h00);
        for (int i = 0; i < 11; i++) rd(0, 8'(i), good_frame[i]);
        gap(3);
        check("u0 rd_data_hold", {24'd0, rdd[0]}, 32'h90);
        pulse_ack(0);
        check("u0 valid_after_ack", {30'd0, fv[0], ok[0]}, 0);
        step();

        // Same frame with corrupted last byte.
        expect_frame(0, 11, 1'b0, 1'b0);
        pulse_fen(0);
        send_bytes(0, bad_frame, 2);
        gap(TO + 2);
        pulse_ack(0);
        step();

        // Overflow on the 4-deep instance, one byte per clock.
        expect_frame(1, 4, 1'b0, 1'b1);
        pulse_fen(1);
        send_bytes(1, ovf_frame, 0);
        gap(TO + 2);
        for (int i = 0; i < 4; i++) rd(1, 8'(i), ovf_frame[i]);
        rd(1, 8'd4, 8'h00);
        pulse_ack(1);
        check("u1 overflow_after_ack", {31'd0, ovf[1]}, 0);
        step();

        // Restart mid-frame, then a 3-byte frame with a good CRC.
        expect_frame(0, 3, 1'b1, 1'b0);
        pulse_fen(0);
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        rd(0, 8'd1, 8'h22);
        pulse_fen(0);
        send_bytes(0, short_ok, 1);
        gap(TO + 2);
        check("u0 valid_short", {31'd0, fv[0]}, 1);

        // F_en while a frame is held: lost, nothing else changes.
        pulse_fen(0);
        check("u0 lost_set", {31'd0, lost[0]}, 1);
        check("u0 valid_kept", {31'd0, fv[0]}, 1);
        send_byte(0, 8'h55);
        gap(2);
        check("u0 len_kept", {23'd0, flen[0]}, 3);
        rd(0, 8'd2, 8'hF0);
        pulse_ack(0);
        check("u0 lost_cleared", {31'd0, lost[0]}, 0);
        check("u0 valid_cleared", {31'd0, fv[0]}, 0);
        // In IDLE a lone byte must not start a frame.
        send_byte(0, 8'h66);
        gap(TO + 4);
        check("u0 idle_no_frame", {31'd0, fv[0]}, 0);

        // F_en together with D_en in IDLE: byte dropped, empty frame.
        expect_frame(0, 0, 1'b0, 1'b0);
        dout[0] = 8'h77;
        d_en[0] = 1'b1;
        f_en[0] = 1'b1;
        step();
        d_en[0] = 1'b0;
        f_en[0] = 1'b0;
        gap(TO + 2);
        check("u0 valid_empty", {31'd0, fv[0]}, 1);
        pulse_fen(0);
        check("u0 lost_again", {31'd0, lost[0]}, 1);
        // F_en and frame_ack together: straight into a new frame.
        expect_frame(0, 3, 1'b1, 1'b0);
        f_en[0] = 1'b1;
        ack[0]  = 1'b1;
        step();
        f_en[0] = 1'b0;
        ack[0]  = 1'b0;
        check("u0 lost_after_fen_ack", {31'd0, lost[0]}, 0);
        check("u0 valid_after_fen_ack", {31'd0, fv[0]}, 0);
        send_bytes(0, short_ok, 0);
        check_close_timing(0);
        pulse_ack(0);
        step();

        // Reset in the middle of a frame.
        pulse_fen(0);
        send_byte(0, 8'h31);
        send_byte(0, 8'h32);
        send_byte(0, 8'h33);
        rst_n = 1'b0;
        #1;
        check_zero(0, "midreset");
        step();
        rst_n = 1'b1;
        gap(TO + 4);
        check("u0 no_frame_after_reset", {31'd0, fv[0]}, 0);
        expect_frame(0, 11, 1'b1, 1'b0);
        pulse_fen(0);
        send_bytes(0, good_frame, 1);
        gap(TO + 2);
        rd(0, 8'd9, 8'h6E);
        pulse_ack(0);
        gap(3);

        check("scoreboard_frames_drained", fq.size(), 0);
        check("scoreboard_reads_drained", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
